// File: rtl/inst_decode_pkg.sv
// Shared constants, decoded-bundle type and helpers for the RV32I ALU decoder.
// Optional skid entry in inst_decode is enabled by defining ZCRV_DECODE_SKID_EN.
package inst_decode_pkg;

   localparam int ZCRV_ADDR_SIZE = 32;
   localparam int ZCRV_IMM_SIZE  = 32;
   localparam int INFO_W         = 12;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] INFO_ADD   = 4'd11;
   localparam logic [3:0] INFO_SUB   = 4'd10;
   localparam logic [3:0] INFO_SLL   = 4'd9;
   localparam logic [3:0] INFO_SLTU  = 4'd8;
   localparam logic [3:0] INFO_XOR   = 4'd7;
   localparam logic [3:0] INFO_OR    = 4'd6;
   localparam logic [3:0] INFO_AND   = 4'd5;
   localparam logic [3:0] INFO_SLT   = 4'd4;
   localparam logic [3:0] INFO_SRL   = 4'd3;
   localparam logic [3:0] INFO_SRA   = 4'd2;
   localparam logic [3:0] INFO_LUI   = 4'd1;
   localparam logic [3:0] INFO_AUIPC = 4'd0;

   typedef struct packed {
      logic [INFO_W-1:0]        inst_info;
      logic [ZCRV_IMM_SIZE-1:0] imm;
      logic                     imm_en;
      logic                     need_alu;
      logic [4:0]               rs1_idx;
      logic [4:0]               rs2_idx;
      logic [4:0]               rd_idx;
      logic                     rd_wen;
      logic                     illegal;
   } dec_t;

   // alt selects the funct7=0100000 flavour (sub / sra)
   function automatic logic [3:0] alu_idx(input logic [2:0] f3, input logic alt);
      logic [3:0] idx;
      case (f3)
         3'd0:    idx = alt ? INFO_SUB : INFO_ADD;
         3'd1:    idx = INFO_SLL;
         3'd2:    idx = INFO_SLT;
         3'd3:    idx = INFO_SLTU;
         3'd4:    idx = INFO_XOR;
         3'd5:    idx = alt ? INFO_SRA : INFO_SRL;
         3'd6:    idx = INFO_OR;
         3'd7:    idx = INFO_AND;
         default: idx = INFO_ADD;
      endcase
      return idx;
   endfunction

   function automatic logic [INFO_W-1:0] onehot(input logic [3:0] idx);
      return 12'd1 << idx;
   endfunction

endpackage

// File: rtl/inst_dec_comb.sv
// Combinational RV32I field decode for the ALU subset (OP, OP-IMM, LUI, AUIPC).
module inst_dec_comb
   import inst_decode_pkg::*;
(
   input  logic [31:0] inst_i,
   output dec_t        dec_o
);

   logic [6:0]               opc_s;
   logic [6:0]               f7_s;
   logic [2:0]               f3_s;
   logic [3:0]               idx_s;
   logic                     op_vld_s;
   logic                     illegal_s;
   logic                     imm_en_s;
   logic [ZCRV_IMM_SIZE-1:0] imm_s;

   assign opc_s = inst_i[6:0];
   assign f3_s  = inst_i[14:12];
   assign f7_s  = inst_i[31:25];

   // Classify the opcode, select the ALU op and flag illegal encodings
   always_comb begin
      idx_s     = INFO_ADD;
      op_vld_s  = 1'b0;
      illegal_s = 1'b0;
      imm_en_s  = 1'b0;
      imm_s     = '0;
      if (inst_i[1:0] != 2'b11) begin
         illegal_s = 1'b1;
      end else begin
         case (opc_s)
            OPC_OP: begin
               op_vld_s  = 1'b1;
               idx_s     = alu_idx(f3_s, f7_s == F7_ALT);
               illegal_s = ((f7_s != F7_BASE) && (f7_s != F7_ALT)) ||
                           ((f7_s == F7_ALT) && (f3_s != 3'd0) && (f3_s != 3'd5));
            end
            OPC_OPIMM: begin
               // inst[31:25] is only an opcode field for the shifts
               op_vld_s  = 1'b1;
               imm_en_s  = 1'b1;
               imm_s     = {{20{inst_i[31]}}, inst_i[31:20]};
               idx_s     = alu_idx(f3_s, (f3_s == 3'd5) && (f7_s == F7_ALT));
               illegal_s = ((f3_s == 3'd1) && (f7_s != F7_BASE)) ||
                           ((f3_s == 3'd5) && (f7_s != F7_BASE) && (f7_s != F7_ALT));
            end
            OPC_LUI, OPC_AUIPC: begin
               op_vld_s = 1'b1;
               imm_en_s = 1'b1;
               imm_s    = {inst_i[31:12], 12'd0};
               idx_s    = (opc_s == OPC_LUI) ? INFO_LUI : INFO_AUIPC;
            end
            default: begin
               op_vld_s = 1'b0;
            end
         endcase
      end
   end

   // Assemble the decoded bundle
   always_comb begin
      dec_o           = '0;
      dec_o.inst_info = (op_vld_s && !illegal_s) ? onehot(idx_s) : 12'd0;
      dec_o.imm       = imm_s;
      dec_o.imm_en    = imm_en_s;
      dec_o.need_alu  = op_vld_s && !illegal_s;
      dec_o.rs1_idx   = inst_i[19:15];
      dec_o.rs2_idx   = inst_i[24:20];
      dec_o.rd_idx    = inst_i[11:7];
      dec_o.rd_wen    = op_vld_s && !illegal_s && (inst_i[11:7] != 5'd0);
      dec_o.illegal   = illegal_s;
   end

endmodule

// File: rtl/inst_decode.sv
// Decode pipeline stage: inst_dec_comb followed by a registered valid/ready bundle.
// Defining ZCRV_DECODE_SKID_EN adds one skid entry and a flop-driven if_ready.
module inst_decode
   import inst_decode_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_valid,
   output logic                      if_ready,
   input  logic [31:0]               if_inst,
   input  logic [ZCRV_ADDR_SIZE-1:0] if_pc,
   input  logic                      flush,
   output logic                      de_valid,
   input  logic                      de_ready,
   output logic [INFO_W-1:0]         de_inst_info,
   output logic [ZCRV_IMM_SIZE-1:0]  de_imm,
   output logic                      de_imm_en,
   output logic                      de_need_alu,
   output logic [4:0]                de_rs1_idx,
   output logic [4:0]                de_rs2_idx,
   output logic [4:0]                de_rd_idx,
   output logic                      de_rd_wen,
   output logic                      de_illegal,
   output logic [ZCRV_ADDR_SIZE-1:0] de_pc
);

   dec_t                      dec_s;
   logic                      accept_s;
   logic                      out_free_s;
   logic                      valid_q, valid_d;
   dec_t                      dec_q, dec_d;
   logic [ZCRV_ADDR_SIZE-1:0] pc_q, pc_d;

   inst_dec_comb u_dec (
      .inst_i (if_inst),
      .dec_o  (dec_s)
   );

   assign out_free_s = ~valid_q | de_ready;
   assign accept_s   = if_valid & if_ready & ~flush;

`ifdef ZCRV_DECODE_SKID_EN
   logic                      skid_full_q, skid_full_d;
   dec_t                      skid_dec_q, skid_dec_d;
   logic [ZCRV_ADDR_SIZE-1:0] skid_pc_q, skid_pc_d;

   assign if_ready = ~rst & ~skid_full_q;

   // Next state: flush wins, a full skid drains before anything new is taken
   always_comb begin
      valid_d     = valid_q;
      dec_d       = dec_q;
      pc_d        = pc_q;
      skid_full_d = skid_full_q;
      skid_dec_d  = skid_dec_q;
      skid_pc_d   = skid_pc_q;
      if (flush) begin
         valid_d     = 1'b0;
         skid_full_d = 1'b0;
      end else if (skid_full_q) begin
         if (out_free_s) begin
            valid_d     = 1'b1;
            dec_d       = skid_dec_q;
            pc_d        = skid_pc_q;
            skid_full_d = 1'b0;
         end else begin
            valid_d = valid_q;
         end
      end else if (accept_s) begin
         if (out_free_s) begin
            valid_d = 1'b1;
            dec_d   = dec_s;
            pc_d    = if_pc;
         end else begin
            skid_full_d = 1'b1;
            skid_dec_d  = dec_s;
            skid_pc_d   = if_pc;
         end
      end else if (de_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Skid entry registers
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_full_q <= 1'b0;
         skid_dec_q  <= '0;
         skid_pc_q   <= '0;
      end else begin
         skid_full_q <= skid_full_d;
         skid_dec_q  <= skid_dec_d;
         skid_pc_q   <= skid_pc_d;
      end
   end
`else
   assign if_ready = ~rst & out_free_s;

   // Next state: flush wins over accept; accept and transfer-out overlap with no bubble
   always_comb begin
      valid_d = valid_q;
      dec_d   = dec_q;
      pc_d    = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept_s) begin
         valid_d = 1'b1;
         dec_d   = dec_s;
         pc_d    = if_pc;
      end else if (de_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end
`endif

   // Output bundle register
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         dec_q   <= dec_d;
         pc_q    <= pc_d;
      end
   end

   assign de_valid     = valid_q;
   assign de_inst_info = dec_q.inst_info;
   assign de_imm       = dec_q.imm;
   assign de_imm_en    = dec_q.imm_en;
   assign de_need_alu  = dec_q.need_alu;
   assign de_rs1_idx   = dec_q.rs1_idx;
   assign de_rs2_idx   = dec_q.rs2_idx;
   assign de_rd_idx    = dec_q.rd_idx;
   assign de_rd_wen    = dec_q.rd_wen;
   assign de_illegal   = dec_q.illegal;
   assign de_pc        = pc_q;

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: directed vector table, stall/flush/reset
// sequences and randomized traffic checked by a decode model plus an in-order queue.
module tb_inst_decode;

   logic        clk = 1'b0;
   logic        rst, if_valid, if_ready, flush, de_valid, de_ready;
   logic [31:0] if_inst, if_pc, de_imm, de_pc;
   logic [11:0] de_inst_info;
   logic        de_imm_en, de_need_alu, de_rd_wen, de_illegal;
   logic [4:0]  de_rs1_idx, de_rs2_idx, de_rd_idx;

   int n_checks = 0;
   int n_fail   = 0;
   int dut_acc  = 0;
   bit last_acc;

   typedef struct packed {
      logic [11:0] info;
      logic [31:0] imm;
      logic        imm_en;
      logic        need_alu;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_wen;
      logic        illegal;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } item_t;

   item_t q[$];
   vec_t  vt[11];

   inst_decode dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_inst(if_inst), .if_pc(if_pc), .flush(flush),
      .de_valid(de_valid), .de_ready(de_ready), .de_inst_info(de_inst_info),
      .de_imm(de_imm), .de_imm_en(de_imm_en), .de_need_alu(de_need_alu),
      .de_rs1_idx(de_rs1_idx), .de_rs2_idx(de_rs2_idx), .de_rd_idx(de_rd_idx),
      .de_rd_wen(de_rd_wen), .de_illegal(de_illegal), .de_pc(de_pc)
   );

   always #5 clk = ~clk;

   // Decode model: mnemonic chosen from the RV32I tables, then turned into the bundle
   function automatic exp_t model_decode(input logic [31:0] w);
      exp_t e;
      int   bitn;
      int   base[8];
      logic [6:0] f7;
      logic [2:0] f3;
      base = '{11, 9, 4, 8, 7, 3, 6, 5};
      e    = '0;
      f7   = w[31:25];
      f3   = w[14:12];
      bitn = -1;
      e.rs1 = w[19:15];
      e.rs2 = w[24:20];
      e.rd  = w[11:7];
      if (w[1:0] != 2'b11) e.illegal = 1'b1;
      else if (w[6:0] == 7'b0110011) begin
         if (f7 == 7'h00) bitn = base[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) bitn = 10;
         else if (f7 == 7'h20 && f3 == 3'd5) bitn = 2;
         else e.illegal = 1'b1;
      end else if (w[6:0] == 7'b0010011) begin
         e.imm_en = 1'b1;
         e.imm    = {{20{w[31]}}, w[31:20]};
         if (f3 == 3'd1 && f7 != 7'h00) e.illegal = 1'b1;
         else if (f3 == 3'd5 && f7 == 7'h20) bitn = 2;
         else if (f3 == 3'd5 && f7 != 7'h00) e.illegal = 1'b1;
         else bitn = base[f3];
      end else if (w[6:0] == 7'b0110111 || w[6:0] == 7'b0010111) begin
         e.imm_en = 1'b1;
         e.imm    = {w[31:12], 12'h000};
         bitn     = (w[6:0] == 7'b0110111) ? 1 : 0;
      end
      if (bitn >= 0 && !e.illegal) e.info = 12'd1 << bitn;
      e.need_alu = (e.info != 12'd0);
      e.rd_wen   = e.need_alu && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 2) w[6:0] = 7'b0110011;
      else if (k <= 5) w[6:0] = 7'b0010011;
      else if (k == 6) w[6:0] = 7'b0110111;
      else if (k == 7) w[6:0] = 7'b0010111;
      if (k <= 5) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
         endcase
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_bundle(input string tag, input exp_t e, input logic [31:0] pc);
      chk({tag, ".info"},     de_inst_info, e.info);
      chk({tag, ".imm"},      de_imm,       e.imm);
      chk({tag, ".imm_en"},   de_imm_en,    e.imm_en);
      chk({tag, ".need_alu"}, de_need_alu,  e.need_alu);
      chk({tag, ".rs1"},      de_rs1_idx,   e.rs1);
      chk({tag, ".rs2"},      de_rs2_idx,   e.rs2);
      chk({tag, ".rd"},       de_rd_idx,    e.rd);
      chk({tag, ".rd_wen"},   de_rd_wen,    e.rd_wen);
      chk({tag, ".illegal"},  de_illegal,   e.illegal);
      chk({tag, ".pc"},       de_pc,        pc);
   endtask

   // One clock: inputs already driven at the negedge; check, update the queue, wait a cycle
   task automatic cycle();
      bit m_valid, m_ready, acc, xfer;
      #1;
      m_valid = (q.size() != 0);
`ifdef ZCRV_DECODE_SKID_EN
      m_ready = !rst && (q.size() < 2);
`else
      m_ready = !rst && (!m_valid || de_ready);
`endif
      chk("de_valid", de_valid, m_valid);
      chk("if_ready", if_ready, m_ready);
      if (m_valid) chk_bundle("out", model_decode(q[0].inst), q[0].pc);
      acc      = if_valid && m_ready && !flush;
      xfer     = m_valid && de_ready;
      last_acc = if_valid && if_ready && !flush;
      if (last_acc) dut_acc++;
      if (rst || flush) q.delete();
      else begin
         if (xfer) void'(q.pop_front());
         if (acc) q.push_back('{if_inst, if_pc});
      end
      @(negedge clk);
   endtask

   initial begin
      int acc0;
      exp_t zero_e;
      zero_e = '0;
      vt[0]  = '{32'hFFF10093, '{12'h800, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd2,  5'd31, 5'd1,  1'b1, 1'b0}};
      vt[1]  = '{32'h402081B3, '{12'h400, 32'h00000000, 1'b0, 1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0}};
      vt[2]  = '{32'h123452B7, '{12'h002, 32'h12345000, 1'b1, 1'b1, 5'd8,  5'd3,  5'd5,  1'b1, 1'b0}};
      vt[3]  = '{32'h02209093, '{12'h000, 32'h00000022, 1'b1, 1'b0, 5'd1,  5'd2,  5'd1,  1'b0, 1'b1}};
      vt[4]  = '{32'h00000000, '{12'h000, 32'h00000000, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1}};
      vt[5]  = '{32'h00000013, '{12'h800, 32'h00000000, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0}};
      vt[6]  = '{32'h4032D213, '{12'h004, 32'h00000403, 1'b1, 1'b1, 5'd5,  5'd3,  5'd4,  1'b1, 1'b0}};
      vt[7]  = '{32'hFFFFF397, '{12'h001, 32'hFFFFF000, 1'b1, 1'b1, 5'd31, 5'd31, 5'd7,  1'b1, 1'b0}};
      vt[8]  = '{32'h4083F333, '{12'h000, 32'h00000000, 1'b0, 1'b0, 5'd7,  5'd8,  5'd6,  1'b0, 1'b1}};
      vt[9]  = '{32'h00C5B533, '{12'h100, 32'h00000000, 1'b0, 1'b1, 5'd11, 5'd12, 5'd10, 1'b1, 1'b0}};
      vt[10] = '{32'h00112023, '{12'h000, 32'h00000000, 1'b0, 1'b0, 5'd2,  5'd1,  5'd0,  1'b0, 1'b0}};

      rst = 1'b1; if_valid = 1'b0; flush = 1'b0; de_ready = 1'b0;
      if_inst = 32'h0; if_pc = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset.de_valid", de_valid, 1'b0);
      chk("reset.if_ready", if_ready, 1'b0);
      chk_bundle("reset", zero_e, 32'h0);
      rst = 1'b0;

      // Directed vector table
      de_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if_valid = 1'b1;
         if_inst  = vt[i].inst;
         if_pc    = 32'h1000 + 32'(4 * i);
         cycle();
         if_valid = 1'b0;
         #1;
         chk_bundle($sformatf("vec%0d", i), vt[i].e, 32'h1000 + 32'(4 * i));
         cycle();
      end

      // Stall: de_ready low for 3 cycles with fetch still offering
      de_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h00C5B533; if_pc = 32'h2000;
      cycle();
      if_inst = 32'hFFF10093; if_pc = 32'h2004;
      acc0 = dut_acc;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (last_acc) if_valid = 1'b0;
      end
`ifdef ZCRV_DECODE_SKID_EN
      chk("stall_accepts", dut_acc - acc0, 1);
`else
      chk("stall_accepts", dut_acc - acc0, 0);
`endif
      de_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (last_acc) if_valid = 1'b0;
      end
      chk("stall_total_accepts", dut_acc - acc0, 1);

      // Flush with a held bundle and a new instruction offered
      de_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h00A00513; if_pc = 32'h3000;
      cycle();
      if_inst = 32'h123452B7; if_pc = 32'h3004; flush = 1'b1;
      cycle();
      flush = 1'b0; if_valid = 1'b0;
      chk("flush_de_valid", de_valid, 1'b0);
      de_ready = 1'b1;
      repeat (3) cycle();

      // Reset in the middle of a stall, then resume
      de_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h00C5B533; if_pc = 32'h4000;
      cycle();
      if_inst = 32'h402081B3; if_pc = 32'h4004;
      cycle();
      rst = 1'b1;
      cycle();
      chk("rst_mid_stall.de_valid", de_valid, 1'b0);
      chk("rst_mid_stall.if_ready", if_ready, 1'b0);
      rst = 1'b0; de_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if_inst = rand_inst();
         if_pc   = 32'h5000 + 32'(4 * i);
         cycle();
      end
      if_valid = 1'b0;
      repeat (3) cycle();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if_valid = ($urandom_range(0, 9) < 7);
         de_ready = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 99) < 3);
         rst      = ($urandom_range(0, 199) == 0);
         if_inst  = rand_inst();
         if_pc    = $urandom;
         cycle();
      end
      if_valid = 1'b0; flush = 1'b0; rst = 1'b0; de_ready = 1'b1;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
